// File: rtl/ntt_sdf_bf.sv
// rtl/ntt_sdf_bf.sv - radix-2 single-path delay-feedback NTT butterfly stage
//
// Pairs sample j with sample j+DELAY of each 2*DELAY-sample frame. Sums stream
// straight out. Twiddled differences go through an external delay-line fifo
// (fb_out -> fb_in, latency DELAY-1). They are emitted during the next frame's
// first half, or during a DELAY-cycle flush when no next frame follows.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_data input coefficient stream (contiguous within a frame)
//   tw / tw_idx      twiddle lookup: tw_idx = cnt in phase 1 else 0, tw same cycle
//   fb_out / fb_in   registered write into delay-line fifo / fifo read data
//   out_valid/data   registered output coefficient stream
//   busy             stage is not idle
//   err              sticky protocol error, cleared only by rst
// Assumes DELAY >= 2.
module ntt_sdf_bf #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int DELAY = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [WIDTH-1:0]         tw,
  output logic [$clog2(DELAY)-1:0] tw_idx,
  output logic [WIDTH-1:0]         fb_out,
  input  logic [WIDTH-1:0]         fb_in,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy,
  output logic                     err
);

  localparam int CW = $clog2(DELAY);
  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);
  localparam logic [2*WIDTH-1:0] QX = (2*WIDTH)'(Q);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          phase;
  logic          pending;

  logic          last_cnt;
  logic          frame_gap;
  logic          mid_drop;
  logic [CW-1:0] cnt_inc;

  logic [2*WIDTH-1:0] a_ext, b_ext, w_ext;
  logic [2*WIDTH-1:0] sum_raw, diff_val, prod_raw;
  logic [WIDTH-1:0]   sum_val, prod_val;

  assign busy   = (state != IDLE);
  assign tw_idx = phase ? cnt : '0;

  // Butterfly arithmetic: a from the delay line, b from the input.
  always_comb begin
    a_ext    = {{WIDTH{1'b0}}, fb_in};
    b_ext    = {{WIDTH{1'b0}}, in_data};
    w_ext    = {{WIDTH{1'b0}}, tw};
    sum_raw  = a_ext + b_ext;
    sum_val  = WIDTH'((sum_raw >= QX) ? (sum_raw - QX) : sum_raw);
    // a-b with Q folded in when b > a, so the result never goes negative.
    diff_val = (a_ext < b_ext) ? (a_ext + QX - b_ext) : (a_ext - b_ext);
    prod_raw = diff_val * w_ext;
    prod_val = WIDTH'(prod_raw % QX);
  end

  always_comb begin
    last_cnt = (cnt == CNT_MAX);
    cnt_inc  = last_cnt ? '0 : cnt + CW'(1);
    // RUN only revisits phase0/cnt0 at a frame boundary; a gap there starts a flush.
    frame_gap = (state == RUN) && !in_valid && !phase && (cnt == '0);
    mid_drop  = (state == RUN) && !in_valid && !frame_gap;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN: begin
        if (frame_gap)     state_next = FLUSH;
        else if (mid_drop) state_next = IDLE;
      end
      FLUSH:   if (last_cnt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      phase     <= 1'b0;
      pending   <= 1'b0;
      fb_out    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            // This cycle is already sample 0 of the frame.
            fb_out <= in_data;
            cnt    <= CW'(1);
            phase  <= 1'b0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (!phase) begin
              fb_out    <= in_data;
              out_valid <= pending;
              if (pending) out_data <= fb_in;
            end else begin
              out_data  <= sum_val;
              out_valid <= 1'b1;
              fb_out    <= prod_val;
            end
            cnt <= cnt_inc;
            if (last_cnt) begin
              phase <= ~phase;
              if (phase) pending <= 1'b1;
            end
          end else if (frame_gap) begin
            // Flush slot 0.
            fb_out    <= '0;
            out_data  <= fb_in;
            out_valid <= pending;
            cnt       <= CW'(1);
          end else begin
            err       <= 1'b1;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            phase     <= 1'b0;
          end
        end
        FLUSH: begin
          fb_out    <= '0;
          out_data  <= fb_in;
          out_valid <= pending;
          if (in_valid) err <= 1'b1;
          cnt <= cnt_inc;
          if (last_cnt) pending <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          cnt       <= '0;
          phase     <= 1'b0;
          pending   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_sdf_bf.sv
// tb/tb_ntt_sdf_bf.sv - directed self-checking bench for ntt_sdf_bf (DELAY=4)
module tb_ntt_sdf_bf;

  localparam int WIDTH = 12;
  localparam int Q     = 3329;
  localparam int DELAY = 4;
  localparam int CW    = $clog2(DELAY);
  localparam int NLOG  = 64;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] tw;
  logic [CW-1:0]    tw_idx;
  logic [WIDTH-1:0] fb_out;
  logic [WIDTH-1:0] fb_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             err;

  ntt_sdf_bf #(.WIDTH(WIDTH), .Q(Q), .DELAY(DELAY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .tw        (tw),
    .tw_idx    (tw_idx),
    .fb_out    (fb_out),
    .fb_in     (fb_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay-line fifo of DELAY-1 stages.
  logic [WIDTH-1:0] fq [0:DELAY-2];
  always @(posedge clk) begin
    fq[0] <= fb_out;
    for (int i = 1; i < DELAY-1; i++) fq[i] <= fq[i-1];
  end
  assign fb_in = fq[DELAY-2];

  // Twiddle ROM indexed by tw_idx.
  logic [WIDTH-1:0] tw_tab [0:DELAY-1];
  assign tw = tw_tab[tw_idx];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus per cycle and per-cycle log of outputs (index = cycle number).
  logic             sv [0:NLOG-1];
  logic [WIDTH-1:0] sd [0:NLOG-1];
  logic             sr [0:NLOG-1];
  logic             lv [0:NLOG-1];
  logic [WIDTH-1:0] ld [0:NLOG-1];
  logic             lb [0:NLOG-1];
  logic             le [0:NLOG-1];
  logic [WIDTH-1:0] lf [0:NLOG-1];
  logic [CW-1:0]    lt [0:NLOG-1];

  task automatic clr();
    for (int i = 0; i < NLOG; i++) begin
      sv[i] = 1'b0; sd[i] = '0; sr[i] = 1'b0;
    end
    for (int i = 0; i < DELAY; i++) tw_tab[i] = WIDTH'(1);
  endtask

  task automatic snap(input int c);
    lv[c] = out_valid; ld[c] = out_data; lb[c] = busy;
    le[c] = err; lf[c] = fb_out; lt[c] = tw_idx;
  endtask

  task automatic play(input int n);
    snap(0);
    for (int c = 0; c < n; c++) begin
      in_valid = sv[c]; in_data = sd[c]; rst = sr[c];
      @(posedge clk); #1;
      snap(c + 1);
    end
    in_valid = 1'b0; in_data = '0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load(input int base, input int v0, input int v1, input int v2, input int v3,
                      input int v4, input int v5, input int v6, input int v7);
    int v [8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) begin
      sv[base+i] = 1'b1; sd[base+i] = WIDTH'(v[i]);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    clr();
    do_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_fb_out",    fb_out,    0);
    check("rst_busy",      busy,      0);
    check("rst_err",       err,       0);
    check("rst_tw_idx",    tw_idx,    0);

    // 1: single frame 1..8 then flush.
    clr();
    load(0, 1, 2, 3, 4, 5, 6, 7, 8);
    play(16);
    for (int c = 1; c <= 4; c++) check($sformatf("t1_nv_c%0d", c), lv[c], 0);
    for (int c = 5; c <= 8; c++) begin
      check($sformatf("t1_v_c%0d", c), lv[c], 1);
      check($sformatf("t1_sum_c%0d", c), ld[c], 6 + 2*(c-5));
    end
    for (int c = 9; c <= 12; c++) begin
      check($sformatf("t1_pv_c%0d", c), lv[c], 1);
      check($sformatf("t1_prod_c%0d", c), ld[c], 3325);
    end
    check("t1_tail_valid", lv[13], 0);
    check("t1_tw_idx_c6",  lt[6], 2);
    check("t1_tw_idx_c2",  lt[2], 0);
    check("t1_busy_c11",   lb[11], 1);
    check("t1_busy_c12",   lb[12], 0);
    check("t1_err",        le[14], 0);

    // 2: modular wrap-around in sum and difference.
    do_reset();
    clr();
    tw_tab[0] = WIDTH'(17);
    load(0, 3000, 5, 0, 0, 1000, 10, 0, 0);
    play(16);
    check("t2_sum_wrap",  ld[5], 671);
    check("t2_sum_small", ld[6], 15);
    check("t2_prod_w17",  ld[9], 710);
    check("t2_diff_neg",  ld[10], 3324);
    check("t2_prod_zero", ld[11], 0);

    // 3: two back-to-back frames.
    do_reset();
    clr();
    load(0, 1, 2, 3, 4, 10, 20, 30, 40);
    load(8, 100, 200, 300, 400, 1, 2, 3, 4);
    play(24);
    for (int c = 5; c < 5 + 3*DELAY; c++) check($sformatf("t3_cont_c%0d", c), lv[c], 1);
    for (int c = 5; c <= 8; c++) check($sformatf("t3_f0sum_c%0d", c), ld[c], 11*(c-4));
    for (int c = 9; c <= 12; c++) check($sformatf("t3_f0prod_c%0d", c), ld[c], Q - 9*(c-8));
    for (int c = 13; c <= 16; c++) check($sformatf("t3_f1sum_c%0d", c), ld[c], 101*(c-12));
    for (int c = 17; c <= 20; c++) begin
      check($sformatf("t3_f1pv_c%0d", c), lv[c], 1);
      check($sformatf("t3_f1prod_c%0d", c), ld[c], 99*(c-16));
    end
    check("t3_tail_valid", lv[21], 0);
    check("t3_busy_end",   lb[21], 0);

    // 4: in_valid drops at phase0 cnt=2.
    do_reset();
    clr();
    sv[0] = 1'b1; sd[0] = WIDTH'(5);
    sv[1] = 1'b1; sd[1] = WIDTH'(6);
    play(6);
    check("t4_busy_before", lb[2], 1);
    check("t4_err_before",  le[2], 0);
    check("t4_err",         le[3], 1);
    check("t4_busy",        lb[3], 0);
    check("t4_out_valid",   lv[3], 0);
    check("t4_err_sticky",  le[6], 1);

    // 5: rst mid-phase1, with err still set from the previous test.
    clr();
    load(0, 7, 8, 9, 10, 20, 30, 40, 50);
    sr[6] = 1'b1;
    play(9);
    check("t5_pre_valid", lv[6], 1);
    check("t5_pre_sum",   ld[6], 38);
    check("t5_pre_err",   le[6], 1);
    check("t5_valid",     lv[7], 0);
    check("t5_busy",      lb[7], 0);
    check("t5_err",       le[7], 0);
    check("t5_fb_out",    lf[7], 0);
    check("t5_stay_idle", lb[9], 0);

    // 6: in_valid during flush slot 2.
    do_reset();
    clr();
    load(0, 1, 2, 3, 4, 10, 20, 30, 40);
    sv[10] = 1'b1; sd[10] = WIDTH'(999);
    play(16);
    check("t6_err_before", le[10], 0);
    check("t6_err",        le[11], 1);
    for (int c = 9; c <= 12; c++) begin
      check($sformatf("t6_pv_c%0d", c), lv[c], 1);
      check($sformatf("t6_prod_c%0d", c), ld[c], Q - 9*(c-8));
    end
    check("t6_busy_end", lb[12], 0);
    check("t6_flush_fb", lf[11], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
